// File: rtl/lsu_mem.sv
// Load/store unit data memory: RISC-V byte/half/word accesses with sign/zero extension,
// configurable wait latency with a ready handshake, and fault reporting.
module lsu_mem #(
    parameter int ADDR_W  = 8,
    parameter int DEPTH   = 64,
    parameter int LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              memRead,
    input  logic              memWrite,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       data,
    output logic [31:0]       dataOut,
    output logic              ready,
    output logic              fault
);

    localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [31:0] mem_q [DEPTH];

    logic              acc_rd_s;
    logic              acc_wr_s;
    logic [2:0]        acc_f3_s;
    logic [ADDR_W-1:0] acc_addr_s;
    logic [31:0]       acc_wdata_s;
    logic              acc_fault_s;
    logic              acc_mis_s;
    logic              acc_store_ok_s;
    logic [31:0]       acc_rdata_s;
    logic [31:0]       acc_wword_s;
    logic [31:0]       widx_s;
    logic [MEM_AW-1:0] midx_s;
    logic [31:0]       rword_s;
    logic [7:0]        rbyte_s;
    logic [15:0]       rhalf_s;
    logic              mem_we_s;

    function automatic logic f3_legal(input logic rd, input logic wr, input logic [2:0] f3);
        logic ok;
        ok = 1'b0;
        if (rd && !wr) begin
            case (f3)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: ok = 1'b1;
                default:                                ok = 1'b0;
            endcase
        end else if (wr && !rd) begin
            case (f3)
                3'b000, 3'b001, 3'b010: ok = 1'b1;
                default:                ok = 1'b0;
            endcase
        end else begin
            ok = 1'b0;
        end
        return ok;
    endfunction

    // Decode, fault detection, load extraction and store word merge
    always_comb begin
        widx_s  = 32'(acc_addr_s[ADDR_W-1:2]);
        midx_s  = widx_s[MEM_AW-1:0];
        rword_s = mem_q[midx_s];
        case (acc_f3_s[1:0])
            2'b01:   acc_mis_s = acc_addr_s[0];
            2'b10:   acc_mis_s = (acc_addr_s[1:0] != 2'b00);
            default: acc_mis_s = 1'b0;
        endcase
        acc_fault_s = (acc_rd_s | acc_wr_s) &&
                      (!f3_legal(acc_rd_s, acc_wr_s, acc_f3_s) || acc_mis_s ||
                       (widx_s >= 32'(DEPTH)));
        acc_store_ok_s = acc_wr_s && !acc_rd_s && !acc_fault_s;
        rbyte_s = rword_s[{acc_addr_s[1:0], 3'b000} +: 8];
        rhalf_s = acc_addr_s[1] ? rword_s[31:16] : rword_s[15:0];
        acc_rdata_s = 32'h0000_0000;
        if (acc_rd_s && !acc_wr_s && !acc_fault_s) begin
            case (acc_f3_s)
                3'b000:  acc_rdata_s = {{24{rbyte_s[7]}}, rbyte_s};
                3'b001:  acc_rdata_s = {{16{rhalf_s[15]}}, rhalf_s};
                3'b010:  acc_rdata_s = rword_s;
                3'b100:  acc_rdata_s = {24'h00_0000, rbyte_s};
                3'b101:  acc_rdata_s = {16'h0000, rhalf_s};
                default: acc_rdata_s = 32'h0000_0000;
            endcase
        end else begin
            acc_rdata_s = 32'h0000_0000;
        end
        acc_wword_s = rword_s;
        case (acc_f3_s[1:0])
            2'b00:   acc_wword_s[{acc_addr_s[1:0], 3'b000} +: 8] = acc_wdata_s[7:0];
            2'b01:   acc_wword_s[{acc_addr_s[1], 4'b0000} +: 16] = acc_wdata_s[15:0];
            default: acc_wword_s = acc_wdata_s;
        endcase
    end

    // Memory write port; the array itself is deliberately never reset
    always_ff @(posedge clk) begin
        if (mem_we_s && !rst) begin
            mem_q[midx_s] <= acc_wword_s;
        end
    end

    generate
        if (LATENCY == 0) begin : g_comb
            assign acc_rd_s    = memRead;
            assign acc_wr_s    = memWrite;
            assign acc_f3_s    = funct3;
            assign acc_addr_s  = addr;
            assign acc_wdata_s = data;
            assign mem_we_s    = acc_store_ok_s;
            assign dataOut     = acc_rdata_s;
            assign fault       = acc_fault_s;
            assign ready       = 1'b1;
        end else begin : g_fsm
            typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

            state_t            state_q, state_d;
            logic [3:0]        cnt_q, cnt_d;
            logic              rd_q, rd_d, wr_q, wr_d;
            logic [2:0]        f3_q, f3_d;
            logic [ADDR_W-1:0] addr_q, addr_d;
            logic [31:0]       wdata_q, wdata_d;
            logic [31:0]       dout_q, dout_d;
            logic              fault_q, fault_d;

            // State, request latch and registered results
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    state_q <= IDLE;
                    cnt_q   <= 4'd0;
                    rd_q    <= 1'b0;
                    wr_q    <= 1'b0;
                    f3_q    <= 3'b000;
                    addr_q  <= '0;
                    wdata_q <= 32'h0000_0000;
                    dout_q  <= 32'h0000_0000;
                    fault_q <= 1'b0;
                end else begin
                    state_q <= state_d;
                    cnt_q   <= cnt_d;
                    rd_q    <= rd_d;
                    wr_q    <= wr_d;
                    f3_q    <= f3_d;
                    addr_q  <= addr_d;
                    wdata_q <= wdata_d;
                    dout_q  <= dout_d;
                    fault_q <= fault_d;
                end
            end

            // Next-state logic; a request still held in DONE is the finished one, so it is ignored
            always_comb begin
                state_d  = state_q;
                cnt_d    = cnt_q;
                rd_d     = rd_q;
                wr_d     = wr_q;
                f3_d     = f3_q;
                addr_d   = addr_q;
                wdata_d  = wdata_q;
                dout_d   = dout_q;
                fault_d  = fault_q;
                ready    = 1'b0;
                mem_we_s = 1'b0;
                case (state_q)
                    IDLE: begin
                        ready = ~(memRead | memWrite);
                        if (memRead || memWrite) begin
                            rd_d    = memRead;
                            wr_d    = memWrite;
                            f3_d    = funct3;
                            addr_d  = addr;
                            wdata_d = data;
                            cnt_d   = 4'(LATENCY - 1);
                            state_d = BUSY;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                    BUSY: begin
                        if (cnt_q != 4'd0) begin
                            cnt_d = cnt_q - 4'd1;
                        end else begin
                            mem_we_s = acc_store_ok_s;
                            dout_d   = acc_rdata_s;
                            fault_d  = acc_fault_s;
                            state_d  = DONE;
                        end
                    end
                    DONE: begin
                        ready   = 1'b1;
                        fault_d = 1'b0;
                        state_d = IDLE;
                    end
                    default: begin
                        state_d = IDLE;
                    end
                endcase
            end

            assign acc_rd_s    = rd_q;
            assign acc_wr_s    = wr_q;
            assign acc_f3_s    = f3_q;
            assign acc_addr_s  = addr_q;
            assign acc_wdata_s = wdata_q;
            assign dataOut     = dout_q;
            assign fault       = fault_q;
        end
    endgenerate

endmodule

// File: tb/tb_lsu_mem.sv
// Bench for lsu_mem: one multi-cycle instance (LATENCY=2, ADDR_W=9) and one LATENCY=0 instance,
// checked against a byte-addressed reference memory.
module tb_lsu_mem;

    localparam int LAT2  = 2;
    localparam int DEPTH = 64;

    logic        clk, rst;
    logic        rd2, wr2, rd0, wr0;
    logic [2:0]  f3_2, f3_0;
    logic [8:0]  a2;
    logic [7:0]  a0;
    logic [31:0] d2, d0, do2, do0;
    logic        rdy2, rdy0, flt2, flt0;

    int total = 0;
    int bad   = 0;

    logic [7:0] bm [2][256];

    typedef struct {
        bit          rd;
        bit          wr;
        logic [2:0]  f3;
        int          addr;
        logic [31:0] data;
        bit          chk_d;
        logic [31:0] exp_d;
        bit          exp_f;
        string       nm;
    } vec_t;

    vec_t tbl[$];

    lsu_mem #(.ADDR_W(9), .DEPTH(DEPTH), .LATENCY(LAT2)) u_d2 (
        .clk(clk), .rst(rst), .memRead(rd2), .memWrite(wr2), .funct3(f3_2),
        .addr(a2), .data(d2), .dataOut(do2), .ready(rdy2), .fault(flt2));

    lsu_mem #(.ADDR_W(8), .DEPTH(DEPTH), .LATENCY(0)) u_d0 (
        .clk(clk), .rst(rst), .memRead(rd0), .memWrite(wr0), .funct3(f3_0),
        .addr(a0), .data(d0), .dataOut(do0), .ready(rdy0), .fault(flt0));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    // Reference: memory as bytes, access rules computed arithmetically
    function automatic void model(input int w, input bit rd, input bit wr, input int f3,
                                  input int a, input logic [31:0] d,
                                  output logic [31:0] res, output bit flt);
        int size;
        bit bad_op;
        logic [31:0] v;
        res = 32'h0;
        flt = 1'b0;
        size = 0;
        if (!rd && !wr) return;
        bad_op = rd && wr;
        if (rd && !wr) begin
            case (f3)
                0, 4:    size = 1;
                1, 5:    size = 2;
                2:       size = 4;
                default: bad_op = 1'b1;
            endcase
        end
        if (wr && !rd) begin
            case (f3)
                0:       size = 1;
                1:       size = 2;
                2:       size = 4;
                default: bad_op = 1'b1;
            endcase
        end
        if (bad_op) flt = 1'b1;
        else flt = ((a % size) != 0) || ((a / 4) >= DEPTH);
        if (flt) return;
        if (rd) begin
            v = 32'h0;
            for (int k = 0; k < size; k++) v = v | (32'(bm[w][a + k]) << (8 * k));
            if (f3 < 4 && size < 4 && v[8 * size - 1]) v = v | (32'hFFFF_FFFF << (8 * size));
            res = v;
        end else begin
            for (int k = 0; k < size; k++) bm[w][a + k] = 8'(d >> (8 * k));
        end
    endfunction

    task automatic run2(input bit rd, input bit wr, input logic [2:0] f3, input int a,
                        input logic [31:0] d, input bit chk_d, input logic [31:0] exp_d,
                        input bit exp_f, input bit hold, input bit scr, input string nm);
        int low;
        rd2 = rd; wr2 = wr; f3_2 = f3; a2 = 9'(a); d2 = d;
        #1;
        low = 0;
        while (rdy2 == 1'b0 && low < 40) begin
            low++;
            @(posedge clk); #1;
            if (scr) begin
                a2 = 9'($urandom); f3_2 = 3'($urandom); d2 = $urandom;
            end
        end
        chk({nm, "_lowcyc"}, 32'(low), 32'(LAT2 + 1));
        chk({nm, "_fault"}, {31'b0, flt2}, {31'b0, exp_f});
        if (chk_d) chk({nm, "_data"}, do2, exp_d);
        if (!hold) begin
            rd2 = 1'b0; wr2 = 1'b0;
        end
        @(posedge clk); #1;
        if (!hold) begin
            chk({nm, "_idlerdy"}, {31'b0, rdy2}, 32'h1);
            chk({nm, "_idleflt"}, {31'b0, flt2}, 32'h0);
            if (chk_d) chk({nm, "_holdd"}, do2, exp_d);
        end
    endtask

    task automatic run0(input bit rd, input bit wr, input logic [2:0] f3, input int a,
                        input logic [31:0] d, input bit chk_d, input logic [31:0] exp_d,
                        input bit exp_f, input string nm);
        rd0 = rd; wr0 = wr; f3_0 = f3; a0 = 8'(a); d0 = d;
        #1;
        chk({nm, "_rdy"}, {31'b0, rdy0}, 32'h1);
        chk({nm, "_fault"}, {31'b0, flt0}, {31'b0, exp_f});
        if (chk_d) chk({nm, "_data"}, do0, exp_d);
        @(posedge clk); #1;
        rd0 = 1'b0; wr0 = 1'b0;
    endtask

    task automatic rand_op(input int amax, output bit rd, output bit wr, output logic [2:0] f3,
                           output int a, output logic [31:0] d);
        int r;
        int lf[5] = '{0, 1, 2, 4, 5};
        r  = int'($urandom_range(0, 9));
        rd = (r < 5) || (r == 9);
        wr = (r >= 5);
        if ($urandom_range(0, 3) == 0) f3 = 3'($urandom_range(0, 7));
        else if (rd) f3 = 3'(lf[$urandom_range(0, 4)]);
        else f3 = 3'($urandom_range(0, 2));
        a = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, amax)) : int'($urandom_range(0, 255));
        if ($urandom_range(0, 3) != 0) begin
            if (f3[1:0] == 2'b10) a = a & ~3;
            else if (f3[1:0] == 2'b01) a = a & ~1;
        end
        d = $urandom;
    endtask

    initial begin
        logic [31:0] er;
        bit ef, rd, wr;
        logic [2:0] f3;
        int a;
        logic [31:0] d;

        rst = 1'b1;
        rd2 = 0; wr2 = 0; f3_2 = 0; a2 = 0; d2 = 0;
        rd0 = 0; wr0 = 0; f3_0 = 0; a0 = 0; d0 = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rdy2", {31'b0, rdy2}, 32'h1);
        chk("rst_dout2", do2, 32'h0);
        chk("rst_flt2", {31'b0, flt2}, 32'h0);
        chk("rst_rdy0", {31'b0, rdy0}, 32'h1);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_rdy2", {31'b0, rdy2}, 32'h1);

        tbl.push_back('{1'b0, 1'b1, 3'd2, 'h10, 32'h8000_00F1, 1'b0, 32'h0, 1'b0, "sw10"});
        tbl.push_back('{1'b1, 1'b0, 3'd0, 'h10, 32'h0, 1'b1, 32'hFFFF_FFF1, 1'b0, "lb10"});
        tbl.push_back('{1'b1, 1'b0, 3'd4, 'h10, 32'h0, 1'b1, 32'h0000_00F1, 1'b0, "lbu10"});
        tbl.push_back('{1'b1, 1'b0, 3'd2, 'h10, 32'h0, 1'b1, 32'h8000_00F1, 1'b0, "lw10"});
        tbl.push_back('{1'b0, 1'b1, 3'd2, 'h10, 32'h1122_3344, 1'b0, 32'h0, 1'b0, "sw10b"});
        tbl.push_back('{1'b0, 1'b1, 3'd0, 'h13, 32'h1234_56AA, 1'b0, 32'h0, 1'b0, "sb13"});
        tbl.push_back('{1'b1, 1'b0, 3'd2, 'h10, 32'h0, 1'b1, 32'hAA22_3344, 1'b0, "lw_sb"});
        tbl.push_back('{1'b0, 1'b1, 3'd1, 'h12, 32'h7777_BEEF, 1'b0, 32'h0, 1'b0, "sh12"});
        tbl.push_back('{1'b1, 1'b0, 3'd2, 'h10, 32'h0, 1'b1, 32'hBEEF_3344, 1'b0, "lw_sh"});
        tbl.push_back('{1'b1, 1'b0, 3'd1, 'h12, 32'h0, 1'b1, 32'hFFFF_BEEF, 1'b0, "lh12"});
        tbl.push_back('{1'b1, 1'b0, 3'd5, 'h12, 32'h0, 1'b1, 32'h0000_BEEF, 1'b0, "lhu12"});
        tbl.push_back('{1'b1, 1'b0, 3'd0, 'h11, 32'h0, 1'b1, 32'h0000_0033, 1'b0, "lb11"});
        tbl.push_back('{1'b1, 1'b0, 3'd4, 'h12, 32'h0, 1'b1, 32'h0000_00EF, 1'b0, "lbu12"});
        tbl.push_back('{1'b0, 1'b1, 3'd2, 'h20, 32'hCAFE_F00D, 1'b0, 32'h0, 1'b0, "sw20"});
        tbl.push_back('{1'b1, 1'b0, 3'd2, 'h11, 32'h0, 1'b1, 32'h0, 1'b1, "f_lw11"});
        tbl.push_back('{1'b0, 1'b1, 3'd1, 'h21, 32'h0000_FFFF, 1'b1, 32'h0, 1'b1, "f_sh21"});
        tbl.push_back('{1'b1, 1'b0, 3'd3, 'h10, 32'h0, 1'b1, 32'h0, 1'b1, "f_ld011"});
        tbl.push_back('{1'b1, 1'b1, 3'd2, 'h10, 32'hDEAD_BEEF, 1'b1, 32'h0, 1'b1, "f_rdwr"});
        tbl.push_back('{1'b1, 1'b0, 3'd2, 'h100, 32'h0, 1'b1, 32'h0, 1'b1, "f_oor"});
        tbl.push_back('{1'b0, 1'b1, 3'd2, 'h104, 32'h0BAD_F00D, 1'b1, 32'h0, 1'b1, "f_sw_oor"});
        tbl.push_back('{1'b0, 1'b1, 3'd4, 'h10, 32'h0, 1'b1, 32'h0, 1'b1, "f_st100"});
        tbl.push_back('{1'b1, 1'b0, 3'd2, 'h10, 32'h0, 1'b1, 32'hBEEF_3344, 1'b0, "unch10"});
        tbl.push_back('{1'b1, 1'b0, 3'd2, 'h20, 32'h0, 1'b1, 32'hCAFE_F00D, 1'b0, "unch20"});

        foreach (tbl[i]) begin
            model(1, tbl[i].rd, tbl[i].wr, int'(tbl[i].f3), tbl[i].addr, tbl[i].data, er, ef);
            run2(tbl[i].rd, tbl[i].wr, tbl[i].f3, tbl[i].addr, tbl[i].data,
                 tbl[i].chk_d, tbl[i].exp_d, tbl[i].exp_f, 1'b0, 1'b0, tbl[i].nm);
        end

        // Back-to-back: first load held through DONE must not be repeated
        run2(1'b1, 1'b0, 3'd2, 'h10, 32'h0, 1'b1, 32'hBEEF_3344, 1'b0, 1'b1, 1'b0, "b2b_a");
        run2(1'b1, 1'b0, 3'd2, 'h20, 32'h0, 1'b1, 32'hCAFE_F00D, 1'b0, 1'b0, 1'b0, "b2b_b");

        // Reset in the middle of a store abandons it
        rd2 = 1'b0; wr2 = 1'b1; f3_2 = 3'd2; a2 = 9'h20; d2 = 32'h5555_5555;
        @(posedge clk); #1;
        chk("rstmid_busy", {31'b0, rdy2}, 32'h0);
        wr2 = 1'b0;
        rst = 1'b1;
        #1;
        chk("rstmid_rdy", {31'b0, rdy2}, 32'h1);
        chk("rstmid_dout", do2, 32'h0);
        chk("rstmid_flt", {31'b0, flt2}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        run2(1'b1, 1'b0, 3'd2, 'h20, 32'h0, 1'b1, 32'hCAFE_F00D, 1'b0, 1'b0, 1'b0, "rstmid_lw");

        // Single-cycle instance
        model(0, 1'b0, 1'b1, 2, 'h04, 32'h1234_5678, er, ef);
        run0(1'b0, 1'b1, 3'd2, 'h04, 32'h1234_5678, 1'b0, 32'h0, 1'b0, "l0_sw");
        model(0, 1'b1, 1'b0, 2, 'h04, 32'h0, er, ef);
        run0(1'b1, 1'b0, 3'd2, 'h04, 32'h0, 1'b1, 32'h1234_5678, 1'b0, "l0_lw");
        run0(1'b1, 1'b0, 3'd1, 'h05, 32'h0, 1'b1, 32'h0, 1'b1, "l0_mis");

        for (int i = 0; i < DEPTH; i++) begin
            d = $urandom;
            model(1, 1'b0, 1'b1, 2, i * 4, d, er, ef);
            run2(1'b0, 1'b1, 3'd2, i * 4, d, 1'b0, er, ef, 1'b0, 1'b0, "init2");
            model(0, 1'b0, 1'b1, 2, i * 4, d, er, ef);
            run0(1'b0, 1'b1, 3'd2, i * 4, d, 1'b0, er, ef, "init0");
        end

        for (int i = 0; i < 200; i++) begin
            rand_op(511, rd, wr, f3, a, d);
            model(1, rd, wr, int'(f3), a, d, er, ef);
            run2(rd, wr, f3, a, d, ef || (rd && !wr), er, ef,
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "rnd2");
        end
        rd2 = 1'b0; wr2 = 1'b0;

        for (int i = 0; i < 200; i++) begin
            rand_op(255, rd, wr, f3, a, d);
            model(0, rd, wr, int'(f3), a, d, er, ef);
            run0(rd, wr, f3, a, d, ef || (rd && !wr), er, ef, "rnd0");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
